// File: rtl/data_mem.sv
// Data-memory responder: byte/half/word loads and stores, one-cycle registered read, sticky error flags.
// Optional saturating illegal-access counter on errCnt when DMEM_ERR_CNT_EN is defined.
module data_mem #(
    parameter int          DEPTH_WORDS       = 1024,
    parameter logic [31:0] BASE_ADDR         = 32'h0000_0000,
    parameter int          ADDR_WIDTH        = 32,
    parameter int          WORD_WIDTH        = 32,
    parameter int          MEMORY_MODE_WIDTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [ADDR_WIDTH-1:0]        addr,
    input  logic [WORD_WIDTH-1:0]        dataIn,
    input  logic                         memRead,
    input  logic                         memWrite,
    input  logic [MEMORY_MODE_WIDTH-1:0] memMode,
    output logic [31:0]                  dataOut,
    output logic                         misalignErr,
    output logic                         rangeErr
`ifdef DMEM_ERR_CNT_EN
    ,
    output logic [15:0]                  errCnt
`endif
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) * 33'd4;

    logic [31:0] mem [DEPTH_WORDS];

    logic [31:0]      off;
    logic [IDX_W-1:0] idx;
    logic [1:0]       lane;
    logic             in_range, misalign, access, legal, wr_en;
    logic [3:0]       be;
    logic [31:0]      wdata, rd_word, rd_shift, load_val;

    logic [31:0] data_out_d, data_out_q;
    logic        misalign_err_d, misalign_err_q;
    logic        range_err_d, range_err_q;

    always_comb begin
        off      = 32'(addr) - BASE_ADDR;
        idx      = off[IDX_W+1:2];
        lane     = off[1:0];
        in_range = (32'(addr) >= BASE_ADDR) && ({1'b0, off} < SPAN);
        // reserved mode 11 behaves as a word access
        misalign = (memMode == 2'b01 && lane[0]) || (memMode[1] && lane != 2'b00);
        access   = memRead || memWrite;
        legal    = in_range && !misalign;
        wr_en    = memWrite && legal && !rst;

        be    = 4'hF;
        wdata = 32'(dataIn);
        case (memMode)
            2'b00: begin
                be    = 4'b0001 << lane;
                wdata = {4{dataIn[7:0]}};
            end
            2'b01: begin
                be    = 4'b0011 << lane;
                wdata = {2{dataIn[15:0]}};
            end
            default: ;
        endcase

        // memory is read before this edge's store lands, giving read-before-write
        rd_word  = mem[idx];
        rd_shift = rd_word >> {lane, 3'b000};
        case (memMode)
            2'b00:   load_val = {{24{rd_shift[7]}}, rd_shift[7:0]};
            2'b01:   load_val = {{16{rd_shift[15]}}, rd_shift[15:0]};
            default: load_val = rd_word;
        endcase

        data_out_d = data_out_q;
        if (memRead)
            data_out_d = legal ? load_val : 32'h0;
        misalign_err_d = misalign_err_q || (access && misalign);
        range_err_d    = range_err_q || (access && !in_range);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_out_q     <= 32'h0;
            misalign_err_q <= 1'b0;
            range_err_q    <= 1'b0;
        end else begin
            data_out_q     <= data_out_d;
            misalign_err_q <= misalign_err_d;
            range_err_q    <= range_err_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (wr_en && be[i])
                mem[idx][8*i +: 8] <= wdata[8*i +: 8];
    end

    assign dataOut     = data_out_q;
    assign misalignErr = misalign_err_q;
    assign rangeErr    = range_err_q;

`ifdef DMEM_ERR_CNT_EN
    logic [15:0] err_cnt_d, err_cnt_q;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (access && !legal && err_cnt_q != 16'hFFFF)
            err_cnt_d = err_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) err_cnt_q <= 16'h0;
        else     err_cnt_q <= err_cnt_d;
    end

    assign errCnt = err_cnt_q;
`endif
endmodule

// File: tb/tb_data_mem.sv
// Scoreboard bench for data_mem: directed ops push expected load results; a monitor pops and compares.
module tb_data_mem;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] dataIn = '0;
    logic        memRead = 1'b0;
    logic        memWrite = 1'b0;
    logic [1:0]  memMode = 2'b10;
    logic [31:0] dataOut;
    logic        misalignErr, rangeErr;
    logic [15:0] errCnt_w;
    logic        probe = 1'b0;

    typedef struct {
        logic [31:0] d;
        logic        m;
        logic        r;
        logic [15:0] c;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;
    logic em = 1'b0, er = 1'b0;
    logic [15:0] ec = 16'h0;

    data_mem dut (
        .clk(clk), .rst(rst), .addr(addr), .dataIn(dataIn),
        .memRead(memRead), .memWrite(memWrite), .memMode(memMode),
        .dataOut(dataOut), .misalignErr(misalignErr), .rangeErr(rangeErr)
`ifdef DMEM_ERR_CNT_EN
        , .errCnt(errCnt_w)
`endif
    );

`ifndef DMEM_ERR_CNT_EN
    assign errCnt_w = 16'h0;
`endif

    always #5 clk = ~clk;

    // one op per rising edge; im/ir say whether this access is misaligned / out of range
    task automatic op(input string nm, input logic rs, input logic r, input logic w, input logic p,
                      input logic [1:0] md, input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] ed, input logic im, input logic ir);
        exp_t e;
        @(posedge clk); #1;
        rst = rs; memRead = r; memWrite = w; probe = p; memMode = md; addr = a; dataIn = wd;
        if (rs) begin
            em = 1'b0; er = 1'b0; ec = 16'h0;
        end else if (r || w) begin
            em = em | im;
            er = er | ir;
            if ((im || ir) && ec != 16'hFFFF) ec = ec + 16'd1;
        end
        if (!rs && (r || p)) begin
            e.d = ed; e.m = em; e.r = er; e.c = ec; e.name = nm;
            sb.push_back(e);
        end
    endtask

    task automatic idle();
        op("idle", 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin : monitor
        logic iss;
        exp_t e;
        forever begin
            @(posedge clk);
            iss = (memRead || probe) && !rst;
            @(negedge clk);
            if (iss) begin
                n_vec++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL underflow: output presented with empty scoreboard, dataOut=%h", dataOut);
                end else begin
                    e = sb.pop_front();
                    if (dataOut !== e.d || misalignErr !== e.m || rangeErr !== e.r
`ifdef DMEM_ERR_CNT_EN
                        || errCnt_w !== e.c
`endif
                    ) begin
                        n_bad++;
                        $display("FAIL %s: got data=%h mis=%b rng=%b cnt=%h, want data=%h mis=%b rng=%b cnt=%h",
                                 e.name, dataOut, misalignErr, rangeErr, errCnt_w, e.d, e.m, e.r, e.c);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        op("rst0", 1'b1, 0, 0, 0, 2'b10, 32'h0, 32'h0, 32'h0, 0, 0);
        op("rst1", 1'b1, 0, 0, 0, 2'b10, 32'h0, 32'h0, 32'h0, 0, 0);
        op("reset_state", 0, 0, 0, 1, 2'b10, 32'h0, 32'h0, 32'h0, 0, 0);
        op("st_w0",  0, 0, 1, 0, 2'b10, 32'h0,  32'h01020304, 32'h0, 0, 0);
        op("st_w10", 0, 0, 1, 0, 2'b10, 32'h10, 32'hDEADBEEF, 32'h0, 0, 0);
        op("ld_w10", 0, 1, 0, 0, 2'b10, 32'h10, 32'h0, 32'hDEADBEEF, 0, 0);
        op("st_w20", 0, 0, 1, 0, 2'b10, 32'h20, 32'h11223344, 32'h0, 0, 0);
        op("st_b21", 0, 0, 1, 0, 2'b00, 32'h21, 32'h00000080, 32'h0, 0, 0);
        op("ld_w20", 0, 1, 0, 0, 2'b10, 32'h20, 32'h0, 32'h11228044, 0, 0);
        op("ld_b21", 0, 1, 0, 0, 2'b00, 32'h21, 32'h0, 32'hFFFFFF80, 0, 0);
        op("ld_h22", 0, 1, 0, 0, 2'b01, 32'h22, 32'h0, 32'h00001122, 0, 0);
        op("ld_b20", 0, 1, 0, 0, 2'b00, 32'h20, 32'h0, 32'h00000044, 0, 0);
        op("ld_h20", 0, 1, 0, 0, 2'b01, 32'h20, 32'h0, 32'hFFFF8044, 0, 0);
        op("ld_b23", 0, 1, 0, 0, 2'b00, 32'h23, 32'h0, 32'h00000011, 0, 0);
        op("st_w30", 0, 0, 1, 0, 2'b10, 32'h30, 32'h55667788, 32'h0, 0, 0);
        op("st_w31_mis", 0, 0, 1, 0, 2'b10, 32'h31, 32'hCAFEF00D, 32'h0, 1, 0);
        op("ld_w30_kept", 0, 1, 0, 0, 2'b10, 32'h30, 32'h0, 32'h55667788, 0, 0);
        op("ld_h33_mis", 0, 1, 0, 0, 2'b01, 32'h33, 32'h0, 32'h0, 1, 0);
        op("ld_w30_again", 0, 1, 0, 0, 2'b10, 32'h30, 32'h0, 32'h55667788, 0, 0);
        op("ld_r11_mis", 0, 1, 0, 0, 2'b11, 32'h32, 32'h0, 32'h0, 1, 0);
        op("ld_w1000_rng", 0, 1, 0, 0, 2'b10, 32'h1000, 32'h0, 32'h0, 0, 1);
        op("st_w1000_rng", 0, 0, 1, 0, 2'b10, 32'h1000, 32'hFFFFFFFF, 32'h0, 0, 1);
        op("ld_w0_noalias", 0, 1, 0, 0, 2'b10, 32'h0, 32'h0, 32'h01020304, 0, 0);
        op("ld_w1001_both", 0, 1, 0, 0, 2'b10, 32'h1001, 32'h0, 32'h0, 1, 1);
        idle();
        op("idle_hold", 0, 0, 0, 1, 2'b10, 32'h0, 32'h0, 32'h0, 0, 0);
        op("st_w40", 0, 0, 1, 0, 2'b10, 32'h40, 32'hAAAA5555, 32'h0, 0, 0);
        op("rw_w40_old", 0, 1, 1, 0, 2'b10, 32'h40, 32'h12345678, 32'hAAAA5555, 0, 0);
        op("ld_w40_new", 0, 1, 0, 0, 2'b10, 32'h40, 32'h0, 32'h12345678, 0, 0);
        op("rst_store", 1'b1, 1, 1, 0, 2'b10, 32'h40, 32'h0BADF00D, 32'h0, 0, 0);
        op("post_rst", 0, 0, 0, 1, 2'b10, 32'h0, 32'h0, 32'h0, 0, 0);
        op("ld_w40_kept", 0, 1, 0, 0, 2'b10, 32'h40, 32'h0, 32'h12345678, 0, 0);
`ifdef DMEM_ERR_CNT_EN
        op("cnt_ill1", 0, 1, 0, 0, 2'b01, 32'h41, 32'h0, 32'h0, 1, 0);
        op("cnt_ill2", 0, 0, 1, 0, 2'b10, 32'h2000, 32'h0, 32'h0, 0, 1);
        op("cnt_ill3", 0, 1, 0, 0, 2'b01, 32'h1003, 32'h0, 32'h0, 1, 1);
        op("cnt_eq3", 0, 0, 0, 1, 2'b10, 32'h0, 32'h0, 32'h0, 0, 0);
        idle();
        @(posedge clk); #1;
        force dut.err_cnt_q = 16'hFFFE;
        @(posedge clk); #1;
        release dut.err_cnt_q;
        ec = 16'hFFFE;
        op("cnt_sat1", 0, 1, 0, 0, 2'b10, 32'h1004, 32'h0, 32'h0, 0, 1);
        op("cnt_sat2", 0, 1, 0, 0, 2'b10, 32'h1008, 32'h0, 32'h0, 0, 1);
`endif
        idle();
        idle();
        @(posedge clk); #1;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expected responses never presented, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
